// File: rtl/spm_pkg.sv
// Shared definitions for the scratchpad arbiter: FSM state encoding,
// default access latency and the byte size of the scratchpad window.
package spm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SPM_WAIT = 2'd1,
        ST_EXT_WAIT = 2'd2,
        ST_RESP     = 2'd3
    } spm_state_e;

    localparam int SPM_LAT_DEF  = 5;
    localparam int ADDR_WID_DEF = 13;

    // Window size in bytes: 2^addr_wid words of 4 bytes. Held at 65 bits so
    // that base + size can be formed for any 64-bit base without wrapping.
    function automatic logic [64:0] win_size(input int addr_wid);
        win_size = 65'd1 << (addr_wid + 2);
    endfunction

    localparam logic [64:0] SPM_WIN_BYTES = win_size(ADDR_WID_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters. Search starts one past the
// last accepted grant; the pointer only moves when the grant is accepted.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] last_q, last_d;

    // Pick the first requester at or after last_q+1, wrapping modulo NUM_REQ.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_o = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    // Remember the index of the accepted grant.
    always_comb begin
        last_d = last_q;
        if (accept_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_o[i]) last_d = IDX_W'(i);
            end
        end
    end

    // Pointer register; reset value makes the first grant go to index 0.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (reset) last_q <= IDX_W'(NUM_REQ - 1);
        else       last_q <= last_d;
    end

endmodule

// File: rtl/spm_arbiter.sv
// Arbitrates NUM_REQ kernel requesters onto one scratchpad port. Byte
// addresses inside [window_base, window_base + window size) go to the
// scratchpad; others go to the external port when SPM_ARB_EXT_EN is
// defined, or complete at once with zero data and req_err otherwise.
module spm_arbiter
    import spm_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_WID = 13,
    parameter int DATA_WID = 32,
    parameter int SPM_LAT  = SPM_LAT_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*64-1:0]       req_addr,
    input  logic [NUM_REQ*DATA_WID-1:0] req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_WID-1:0]         rsp_rdata,
    input  logic [63:0]                 window_base,
    output logic                        spm_ce,
    output logic                        spm_we,
    output logic [ADDR_WID-1:0]         spm_addr,
    output logic [DATA_WID-1:0]         spm_d,
    input  logic [DATA_WID-1:0]         spm_q,
`ifdef SPM_ARB_EXT_EN
    output logic                        ext_rd_en,
    output logic                        ext_wr_en,
    output logic [63:0]                 ext_addr,
    output logic [DATA_WID-1:0]         ext_wdata,
    input  logic [DATA_WID-1:0]         ext_rdata,
    input  logic                        ext_ready,
`endif
    output logic                        busy
`ifndef SPM_ARB_EXT_EN
   ,output logic                        req_err
`endif
);

    localparam int          CNT_W = $clog2(SPM_LAT + 1);
    localparam logic [64:0] WIN   = win_size(ADDR_WID);

    spm_state_e state_q, state_d;

    logic [NUM_REQ-1:0]  gnt_oh, gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [ADDR_WID-1:0] word_q, word_d;
    logic [DATA_WID-1:0] wdata_q, wdata_d;
    logic [DATA_WID-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef SPM_ARB_EXT_EN
    logic [63:0]         eaddr_q, eaddr_d;
`else
    logic                oow_q, oow_d;
`endif

    logic                accept;
    logic                sel_we;
    logic [63:0]         sel_addr;
    logic [DATA_WID-1:0] sel_wdata;
    logic                sel_in_win;
    logic [ADDR_WID-1:0] sel_word;

    assign accept = (state_q == ST_IDLE) && (|req_valid);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req_i   (req_valid),
        .accept_i(accept),
        .grant_o (gnt_oh)
    );

    // Select the granted requester's payload and classify its address.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) begin
                sel_we    |= req_we[i];
                sel_addr  |= req_addr[i*64 +: 64];
                sel_wdata |= req_wdata[i*DATA_WID +: DATA_WID];
            end
        end
        sel_in_win = ({1'b0, sel_addr} >= {1'b0, window_base}) &&
                     ({1'b0, sel_addr} <  {1'b0, window_base} + WIN);
        sel_word   = ADDR_WID'((sel_addr - window_base) >> 2);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
`ifdef SPM_ARB_EXT_EN
                    state_d = sel_in_win ? ST_SPM_WAIT : ST_EXT_WAIT;
`else
                    state_d = sel_in_win ? ST_SPM_WAIT : ST_RESP;
`endif
                end
            end
            ST_SPM_WAIT: if (cnt_q == '0) state_d = ST_RESP;
`ifdef SPM_ARB_EXT_EN
            ST_EXT_WAIT: if (ext_ready) state_d = ST_RESP;
`endif
            ST_RESP:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Transaction registers: latch payload at grant, count latency, capture data.
    always_comb begin
        gnt_d   = gnt_q;
        we_d    = we_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
`ifdef SPM_ARB_EXT_EN
        eaddr_d = eaddr_q;
`else
        oow_d   = oow_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    gnt_d   = gnt_oh;
                    we_d    = sel_we;
                    word_d  = sel_word;
                    wdata_d = sel_wdata;
                    rdata_d = '0;
                    cnt_d   = CNT_W'(SPM_LAT - 1);
`ifdef SPM_ARB_EXT_EN
                    eaddr_d = sel_addr;
`else
                    oow_d   = !sel_in_win;
`endif
                end
            end
            ST_SPM_WAIT: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                else if (!we_q)  rdata_d = spm_q;
            end
`ifdef SPM_ARB_EXT_EN
            ST_EXT_WAIT: if (ext_ready && !we_q) rdata_d = ext_rdata;
`endif
            default: ;
        endcase
    end

    // Transaction register bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q   <= '0;
            we_q    <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
`ifdef SPM_ARB_EXT_EN
            eaddr_q <= '0;
`else
            oow_q   <= 1'b0;
`endif
        end else begin
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
`ifdef SPM_ARB_EXT_EN
            eaddr_q <= eaddr_d;
`else
            oow_q   <= oow_d;
`endif
        end
    end

    // Outputs decoded from state; data buses are zero whenever idle.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        spm_ce    = (state_q == ST_SPM_WAIT) && (cnt_q == CNT_W'(SPM_LAT - 1));
        spm_we    = spm_ce && we_q;
        spm_addr  = spm_ce ? word_q  : '0;
        spm_d     = spm_we ? wdata_q : '0;
        req_ready = (state_q == ST_RESP) ? gnt_q   : '0;
        rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
`ifdef SPM_ARB_EXT_EN
        ext_rd_en = (state_q == ST_EXT_WAIT) && !we_q;
        ext_wr_en = (state_q == ST_EXT_WAIT) &&  we_q;
        ext_addr  = (state_q == ST_EXT_WAIT) ? eaddr_q : '0;
        ext_wdata = ext_wr_en ? wdata_q : '0;
`else
        req_err   = (state_q == ST_RESP) && oow_q;
`endif
    end

endmodule
